czioport: RTL

- Port-mapped peripheral on the CPU's I/O bus: the responder side of OUTPUT/OUTPUTK/INPUT transactions.
- Decodes PORTID and the write/read strobes, holds a general-purpose output latch, samples a general-purpose input, runs a prescaled 16-bit down-timer and drives the CPU's two interrupt request lines.
- Sits beside the CPU top: its xINPORT_P feeds the CPU input port and its xINT0_P/xINT1_P feed the CPU interrupts.

---
 rtl/czioport.sv | 93 +++++++++
 1 files changed

// File: rtl/czioport.sv
// czioport: port-mapped I/O responder with GPO latch, synchronised GPI with
// change interrupt, and a prescaled 16-bit down-timer with interrupt.
module czioport #(
    parameter logic [7:0] BASE     = 8'h00,
    parameter int         PRESCALE = 16
) (
    input  logic       CLK,
    input  logic       xRESETN_P,
    input  logic [7:0] xPORTID_P,
    input  logic [7:0] xOUTPORT_P,
    input  logic       xWSTROBE_P,
    input  logic       xWSTROBEK_P,
    input  logic       xRSTROBE_P,
    input  logic [7:0] xGPI_P,
    output logic [7:0] xINPORT_P,
    output logic [7:0] xGPO_P,
    output logic       xINT0_P,
    output logic       xINT1_P
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;

    logic [7:0]    reload_l, reload_h, hi_snap, gpi_s1, gpi_s2, gpi_prev, rd;
    logic [3:0]    ctrl;
    logic          tpend, gpend;
    logic [15:0]   cnt;
    logic [PW-1:0] pre;
    logic          hit, we, wr_ctrl, ten_rise, tick, expire, gpi_chg;
    logic [2:0]    off;

    assign hit      = xPORTID_P[7:3] == BASE[7:3];
    assign off      = xPORTID_P[2:0];
    // OUTPUTK only decodes PORTID[3], so the upper nibble is don't-care
    assign we       = (xWSTROBE_P && hit) || (xWSTROBEK_P && xPORTID_P[3] == BASE[3]);
    assign wr_ctrl  = we && off == 3'd4;
    assign ten_rise = wr_ctrl && xOUTPORT_P[0] && !ctrl[0];
    assign tick     = ctrl[0] && pre == PW'(PRESCALE - 1);
    assign expire   = tick && cnt == 16'd0;
    assign gpi_chg  = gpi_s2 != gpi_prev;

    always_comb begin
        rd = 8'h00;
        if (hit)
            case (off)
                3'd0: rd = xGPO_P;
                3'd1: rd = gpi_s2;
                3'd2: rd = reload_l;
                3'd3: rd = reload_h;
                3'd4: rd = {4'h0, ctrl};
                3'd5: rd = {6'b0, gpend, tpend};
                3'd6: rd = cnt[7:0];
                default: rd = hi_snap;
            endcase
    end

    always_ff @(posedge CLK or negedge xRESETN_P) begin
        if (!xRESETN_P) begin
            xGPO_P    <= '0;
            reload_l  <= '0;
            reload_h  <= '0;
            ctrl      <= '0;
            tpend     <= 1'b0;
            gpend     <= 1'b0;
            cnt       <= '0;
            hi_snap   <= '0;
            pre       <= '0;
            gpi_s1    <= '0;
            gpi_s2    <= '0;
            gpi_prev  <= '0;
            xINPORT_P <= '0;
            xINT0_P   <= 1'b0;
            xINT1_P   <= 1'b0;
        end else begin
            if (we && off == 3'd0) xGPO_P <= xOUTPORT_P;
            if (we && off == 3'd2) reload_l <= xOUTPORT_P;
            if (we && off == 3'd3) reload_h <= xOUTPORT_P;
            if (wr_ctrl) ctrl <= xOUTPORT_P[3:0];
            else if (expire && !ctrl[1]) ctrl[0] <= 1'b0;
            pre <= (!ctrl[0] || tick) ? '0 : pre + 1'b1;
            if (ten_rise) cnt <= {reload_h, reload_l};
            else if (tick) cnt <= cnt != 16'd0 ? cnt - 16'd1 : (ctrl[1] ? {reload_h, reload_l} : 16'd0);
            // a set in the same cycle as its W1C clear wins
            tpend <= expire || (tpend && !(we && off == 3'd5 && xOUTPORT_P[0]));
            gpend <= gpi_chg || (gpend && !(we && off == 3'd5 && xOUTPORT_P[1]));
            gpi_s1   <= xGPI_P;
            gpi_s2   <= gpi_s1;
            gpi_prev <= gpi_s2;
            if (xRSTROBE_P && hit && off == 3'd6) hi_snap <= cnt[15:8];
            xINPORT_P <= rd;
            xINT0_P   <= tpend & ctrl[2];
            xINT1_P   <= gpend & ctrl[3];
        end
    end
endmodule
